// File: rtl/alu_execute.sv
// Execute-stage ALU: condition check against NZCV, 16 data-processing opcodes,
// optional flag update, and a registered valid/ready output stage.
module alu_execute #(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  cond,
   input  logic [3:0]  opcode,
   input  logic        s_flag,
   input  logic [31:0] rn_value,
   input  logic [31:0] operand2,
   input  logic        shifter_carry,
   input  logic [3:0]  rd_index,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic [3:0]  out_rd,
   output logic        out_write,
   output logic [3:0]  flags
);

   localparam int unsigned DW = 32;

   localparam logic [3:0] OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3;
   localparam logic [3:0] OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7;
   localparam logic [3:0] OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11;
   localparam logic [3:0] OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15;

   logic          flag_n, flag_z, flag_c, flag_v;
   logic          accept;
   logic          cond_pass;
   logic          compare_op;
   logic          arith;
   logic [DW-1:0] op_x, op_y;
   logic          cin;
   logic [DW:0]   sum;
   logic [DW-1:0] alu_res;
   logic [3:0]    new_flags;

   assign {flag_n, flag_z, flag_c, flag_v} = flags;
   assign in_ready   = !flush && (!out_valid || out_ready);
   assign accept     = in_valid && in_ready;
   assign compare_op = (opcode[3:2] == 2'b10);

   // Condition field evaluated against the current flags register
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'd0:    cond_pass = flag_z;
         4'd1:    cond_pass = !flag_z;
         4'd2:    cond_pass = flag_c;
         4'd3:    cond_pass = !flag_c;
         4'd4:    cond_pass = flag_n;
         4'd5:    cond_pass = !flag_n;
         4'd6:    cond_pass = flag_v;
         4'd7:    cond_pass = !flag_v;
         4'd8:    cond_pass = flag_c && !flag_z;
         4'd9:    cond_pass = !flag_c || flag_z;
         4'd10:   cond_pass = (flag_n == flag_v);
         4'd11:   cond_pass = (flag_n != flag_v);
         4'd12:   cond_pass = !flag_z && (flag_n == flag_v);
         4'd13:   cond_pass = flag_z || (flag_n != flag_v);
         4'd14:   cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Subtracts run as x + ~y + cin so bit 32 is directly NOT-borrow
   always_comb begin
      op_x  = rn_value;
      op_y  = operand2;
      cin   = 1'b0;
      arith = 1'b0;
      case (opcode)
         OP_SUB, OP_CMP: begin op_y = ~operand2; cin = 1'b1;   arith = 1'b1; end
         OP_RSB: begin op_x = operand2; op_y = ~rn_value; cin = 1'b1; arith = 1'b1; end
         OP_ADD, OP_CMN: arith = 1'b1;
         OP_ADC: begin cin = flag_c; arith = 1'b1; end
         OP_SBC: begin op_y = ~operand2; cin = flag_c; arith = 1'b1; end
         OP_RSC: begin op_x = operand2; op_y = ~rn_value; cin = flag_c; arith = 1'b1; end
         default: ;
      endcase
   end

   assign sum = {1'b0, op_x} + {1'b0, op_y} + (DW+1)'(cin);

   always_comb begin
      alu_res = sum[DW-1:0];
      case (opcode)
         OP_AND, OP_TST: alu_res = rn_value & operand2;
         OP_EOR, OP_TEQ: alu_res = rn_value ^ operand2;
         OP_ORR:         alu_res = rn_value | operand2;
         OP_MOV:         alu_res = operand2;
         OP_BIC:         alu_res = rn_value & ~operand2;
         OP_MVN:         alu_res = ~operand2;
         default:        alu_res = sum[DW-1:0];
      endcase
   end

   always_comb begin
      new_flags[3] = alu_res[DW-1];
      new_flags[2] = (alu_res == '0);
      new_flags[1] = arith ? sum[DW] : shifter_carry;
      new_flags[0] = arith ? ((op_x[DW-1] == op_y[DW-1]) && (sum[DW-1] != op_x[DW-1]))
                           : flag_v;
   end

   // Output register and flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_rd    <= '0;
         out_write <= 1'b0;
         flags     <= RESET_FLAGS;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            out_rd    <= rd_index;
            out_write <= cond_pass && !compare_op;
            if (cond_pass && (s_flag || compare_op))
               flags <= new_flags;
         end else if (flush || out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_execute.sv
// Directed bench for alu_execute with hand-computed expectations.
module tb_alu_execute;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  cond;
   logic [3:0]  opcode;
   logic        s_flag;
   logic [31:0] rn_value;
   logic [31:0] operand2;
   logic        shifter_carry;
   logic [3:0]  rd_index;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic [3:0]  out_rd;
   logic        out_write;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   alu_execute #(.RESET_FLAGS(4'b0000)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .cond(cond), .opcode(opcode), .s_flag(s_flag), .rn_value(rn_value),
      .operand2(operand2), .shifter_carry(shifter_carry), .rd_index(rd_index),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_rd(out_rd), .out_write(out_write), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [3:0] c, input logic [3:0] op, input logic s,
                            input logic [31:0] a, input logic [31:0] b, input logic sc,
                            input logic [3:0] rd);
      cond = c; opcode = op; s_flag = s; rn_value = a; operand2 = b;
      shifter_carry = sc; rd_index = rd;
   endtask

   // One-shot issue: present for one edge, then drop in_valid
   task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic sc,
                        input logic [3:0] rd);
      set_instr(c, op, s, a, b, sc, rd);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      set_instr(4'd14, 4'd0, 1'b0, 32'h0, 32'h0, 1'b0, 4'd0);
      #2;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", 32'(flags), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD wrap to zero
      issue(4'd14, 4'd4, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 4'd3);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_result", result, 32'h0);
      chk("add_write", 32'(out_write), 32'd1);
      chk("add_rd", 32'(out_rd), 32'd3);
      chk("add_flags", 32'(flags), 32'b0110);

      // CMP with signed overflow, then ADC consumes C=1
      issue(4'd14, 4'd10, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 4'd4);
      chk("cmp_write", 32'(out_write), 32'd0);
      chk("cmp_result", result, 32'h7FFF_FFFF);
      chk("cmp_flags", 32'(flags), 32'b0011);
      issue(4'd14, 4'd5, 1'b0, 32'd5, 32'd7, 1'b0, 4'd1);
      chk("adc_result", result, 32'd13);
      chk("adc_flags", 32'(flags), 32'b0011);

      // EQ fails with Z=0; NE passes
      issue(4'd0, 4'd4, 1'b1, 32'd3, 32'd4, 1'b0, 4'd2);
      chk("eq_valid", 32'(out_valid), 32'd1);
      chk("eq_write", 32'(out_write), 32'd0);
      chk("eq_flags", 32'(flags), 32'b0011);
      issue(4'd1, 4'd4, 1'b0, 32'd3, 32'd4, 1'b0, 4'd2);
      chk("ne_result", result, 32'd7);
      chk("ne_write", 32'(out_write), 32'd1);

      // Backpressure: held output, no accept until out_ready
      out_ready = 1'b0;
      set_instr(4'd14, 4'd2, 1'b0, 32'd20, 32'd3, 1'b0, 4'd5);
      in_valid = 1'b1;
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_result", result, 32'd7);
         chk("bp_rd", 32'(out_rd), 32'd2);
         chk("bp_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_sub_result", result, 32'd17);
      chk("bp_sub_rd", 32'(out_rd), 32'd5);

      // MOV keeps V, takes shifter carry
      issue(4'd14, 4'd13, 1'b1, 32'h0, 32'h8000_0000, 1'b1, 4'd6);
      chk("mov_result", result, 32'h8000_0000);
      chk("mov_flags", 32'(flags), 32'b1011);

      // GE passes (N==V), RSB borrows
      issue(4'd10, 4'd3, 1'b1, 32'd1, 32'd0, 1'b0, 4'd7);
      chk("rsb_result", result, 32'hFFFF_FFFF);
      chk("rsb_flags", 32'(flags), 32'b1000);
      // LT passes (N!=V), SBC with C=0
      issue(4'd11, 4'd6, 1'b1, 32'd5, 32'd2, 1'b0, 4'd8);
      chk("sbc_result", result, 32'd2);
      chk("sbc_flags", 32'(flags), 32'b0010);

      // Flush while holding output and upstream valid
      out_ready = 1'b0;
      flush = 1'b1;
      set_instr(4'd14, 4'd4, 1'b1, 32'h0, 32'h0, 1'b0, 4'd9);
      in_valid = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", 32'(out_valid), 32'd0);
      chk("flush_flags", 32'(flags), 32'b0010);
      chk("flush_result", result, 32'd2);

      // Reset mid-stream
      issue(4'd14, 4'd12, 1'b0, 32'hF0, 32'h0F, 1'b0, 4'd10);
      chk("orr_result", result, 32'hFF);
      rst_n = 1'b0;
      #1;
      chk("rst2_valid", 32'(out_valid), 32'd0);
      chk("rst2_result", result, 32'd0);
      chk("rst2_rd", 32'(out_rd), 32'd0);
      chk("rst2_write", 32'(out_write), 32'd0);
      chk("rst2_flags", 32'(flags), 32'd0);
      step();
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
